// File: rtl/phys_reg_file_pkg.sv
// Shared backend constants and types for the physical register file and forwarding unit.
package phys_reg_file_pkg;

  localparam int unsigned NUM_PREGS    = 64;
  localparam int unsigned PREG_W       = $clog2(NUM_PREGS);
  localparam int unsigned XLEN         = 32;
  localparam int unsigned NUM_WB_PORTS = 2;

  typedef logic [PREG_W-1:0] preg_idx_t;

endpackage

// File: rtl/prf_ready_table.sv
// Per-preg ready scoreboard: cleared on rename allocation, set on writeback.
// PRF_WR_BYPASS_EN makes same-cycle writebacks visible on the query ports.
module prf_ready_table
  import phys_reg_file_pkg::*;
#(
  parameter int unsigned NUM_PREGS = phys_reg_file_pkg::NUM_PREGS,
  parameter int unsigned PREG_W    = $clog2(NUM_PREGS),
  parameter int unsigned NUM_WB    = NUM_WB_PORTS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg,
  input  logic                           alloc_valid,
  input  logic [PREG_W-1:0]              alloc_preg,
  input  logic [PREG_W-1:0]              q1_preg,
  input  logic [PREG_W-1:0]              q2_preg,
  output logic                           q1_rdy,
  output logic                           q2_rdy
);

  logic [NUM_PREGS-1:0] ready;

  // Alloc is applied after the wb loop so it wins on a same-preg collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && wb_preg[i] != '0) ready[wb_preg[i]] <= 1'b1;
      end
      if (alloc_valid && alloc_preg != '0) ready[alloc_preg] <= 1'b0;
    end
  end

`ifdef PRF_WR_BYPASS_EN
  always_comb begin
    q1_rdy = ready[q1_preg];
    q2_rdy = ready[q2_preg];
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wb_preg[i] == q1_preg && q1_preg != '0 &&
          !(alloc_valid && alloc_preg == q1_preg)) q1_rdy = 1'b1;
      if (wb_valid[i] && wb_preg[i] == q2_preg && q2_preg != '0 &&
          !(alloc_valid && alloc_preg == q2_preg)) q2_rdy = 1'b1;
    end
  end
`else
  always_comb begin
    q1_rdy = ready[q1_preg];
    q2_rdy = ready[q2_preg];
  end
`endif

endmodule

// File: rtl/phys_reg_file.sv
// Physical register file: async 2-read, NUM_WB-write data array plus ready scoreboard.
// PRF_WR_BYPASS_EN adds combinational write-to-read bypass on data and ready.
module phys_reg_file
  import phys_reg_file_pkg::*;
#(
  parameter int unsigned NUM_PREGS = phys_reg_file_pkg::NUM_PREGS,
  parameter int unsigned PREG_W    = $clog2(NUM_PREGS),
  parameter int unsigned NUM_WB    = NUM_WB_PORTS,
  parameter int unsigned XLEN      = phys_reg_file_pkg::XLEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PREG_W-1:0]              src1_reg,
  input  logic [PREG_W-1:0]              src2_reg,
  output logic [XLEN-1:0]                src1_val,
  output logic [XLEN-1:0]                src2_val,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg,
  input  logic [NUM_WB-1:0][XLEN-1:0]    wb_data,
  input  logic                           alloc_valid,
  input  logic [PREG_W-1:0]              alloc_preg,
  input  logic [PREG_W-1:0]              rdy_q1_preg,
  input  logic [PREG_W-1:0]              rdy_q2_preg,
  output logic                           rdy_q1,
  output logic                           rdy_q2,
  output logic                           wr_conflict
);

  logic [XLEN-1:0] mem [NUM_PREGS];
  logic [XLEN-1:0] rd1, rd2;
  logic            conflict_d;

  // Ascending port loop: the highest-index writer to a preg takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && wb_preg[i] != '0) mem[wb_preg[i]] <= wb_data[i];
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      for (int unsigned j = i + 1; j < NUM_WB; j++) begin
        if (wb_valid[i] && wb_valid[j] && wb_preg[i] == wb_preg[j] && wb_preg[i] != '0)
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_d;
  end

  assign rd1 = (src1_reg == '0) ? '0 : mem[src1_reg];
  assign rd2 = (src2_reg == '0) ? '0 : mem[src2_reg];

`ifdef PRF_WR_BYPASS_EN
  always_comb begin
    src1_val = rd1;
    src2_val = rd2;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wb_preg[i] == src1_reg && src1_reg != '0) src1_val = wb_data[i];
      if (wb_valid[i] && wb_preg[i] == src2_reg && src2_reg != '0) src2_val = wb_data[i];
    end
  end
`else
  always_comb begin
    src1_val = rd1;
    src2_val = rd2;
  end
`endif

  prf_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .PREG_W    (PREG_W),
    .NUM_WB    (NUM_WB)
  ) u_ready (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .q1_preg     (rdy_q1_preg),
    .q2_preg     (rdy_q2_preg),
    .q1_rdy      (rdy_q1),
    .q2_rdy      (rdy_q2)
  );

endmodule

// File: doc/phys_reg_file.md
Name: phys_reg_file

Overview:
- Physical register file (PRF) for the out-of-order backend.
- Acts as the responder on the register-read/PRF interface: register_read drives two source preg indices and samples two operand values in the same cycle.
- Also accepts writeback results from the execute ports.
- Holds a per-preg ready scoreboard: cleared on rename allocation, set on writeback, queried by the scheduler for wakeup.

Parameters:
- NUM_PREGS, 64: number of physical registers; power of two, at least 32.
- PREG_W, $clog2(NUM_PREGS): preg index width.
- NUM_WB, 2: number of writeback ports.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src1_reg  in  PREG_W  read port 1 index (from register_read)
- src2_reg  in  PREG_W  read port 2 index
- src1_val  out  XLEN  read port 1 data
- src2_val  out  XLEN  read port 2 data
- wb_valid  in  NUM_WB  per-port write enable
- wb_preg  in  NUM_WB x PREG_W  write index per port
- wb_data  in  NUM_WB x XLEN  write data per port
- alloc_valid  in  1  rename allocated a new destination preg
- alloc_preg  in  PREG_W  allocated preg index
- rdy_q1_preg  in  PREG_W  scheduler ready query 1
- rdy_q2_preg  in  PREG_W  scheduler ready query 2
- rdy_q1  out  1  ready bit for query 1 (combinational)
- rdy_q2  out  1  ready bit for query 2 (combinational)
- wr_conflict  out  1  registered: two wb ports wrote the same nonzero preg in the previous cycle

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
  - Clock port is clk, reset port is rst.
  - All state updates occur on posedge clk.
- Reset state:
  - All data entries = 0.
  - All ready bits = 1.
  - wr_conflict = 0.
  - Read outputs follow storage, so src*_val = 0 after reset.
  - Reset asserted mid-operation discards that cycle's writes and allocs; state is reset-valued on the next cycle.
- Reads:
  - Asynchronous, zero-latency. srcN_val = mem[srcN_reg] in the same cycle, because register_read registers the value into its execute packet.
  - Index 0 always reads 0.
- Writes:
  - Registered. For each port i with wb_valid[i] and wb_preg[i] != 0: mem[wb_preg[i]] <= wb_data[i] and ready[wb_preg[i]] <= 1.
  - Writes to preg 0 are ignored, and preg 0 stays ready.
  - Two ports writing the same preg in one cycle: the highest port index wins, and wr_conflict is set to 1 on the next cycle (cleared the cycle after unless repeated).
- Read-during-write (same cycle, same index):
  - Without the optional feature, the read returns the old value.
  - The forwarding unit covers this case.
- Allocation:
  - alloc_valid with alloc_preg != 0 sets ready[alloc_preg] <= 0; data is untouched.
  - alloc_preg == 0 is ignored.
- Alloc and wb to the same preg in the same cycle: alloc wins, so ready = 0 and data is still written.
- Ready queries:
  - rdy_qN = ready[rdy_qN_preg], reflecting the stored state.
  - Same-cycle writebacks are visible only under the optional feature.
- No flush port. Rename recovery re-establishes ready state by the normal wb path.

Optional Feature:
- Macro: PRF_WR_BYPASS_EN.
- Defined:
  - Combinational write-to-read bypass. If any wb port i has wb_valid[i] and wb_preg[i] == srcN_reg != 0, then srcN_val = wb_data[i] (highest i wins).
  - Same bypass for ready: rdy_qN = 1 on a matching valid wb, unless alloc_valid targets the same preg that cycle.
- Undefined: reads and ready queries return stored state only.

Decomposition:
- Shared backend package:
  - preg_idx_t typedef (PREG_W bits).
  - XLEN and NUM_PREGS constants.
  - NUM_WB_PORTS constant, also used by the forwarding unit.
- One natural sub-module: prf_ready_table (ready-bit array, alloc/wb update, query ports), instantiated once.
- Data array and bypass muxing stay in phys_reg_file.

Test Plan:
- Reset then read p5/p63 -> src1_val = src2_val = 0; rdy_q1 = rdy_q2 = 1; wr_conflict = 0.
- alloc p7 at cycle 1 -> rdy_q1(p7) = 0 at cycle 2. wb0 p7 = 0xDEADBEEF at cycle 3 -> cycle 4: src1_val = 0xDEADBEEF, rdy_q1 = 1.
- wb0 p0 = 0x1234 -> src1(p0) reads 0, rdy(p0) = 1.
- wb0 p9 = 0xA and wb1 p9 = 0xB in the same cycle -> p9 reads 0xB next cycle; wr_conflict = 1 for one cycle.
- Same-cycle alloc p12 and wb0 p12 = 0x55 -> next cycle: rdy(p12) = 0, src(p12) = 0x55.
- Read p20 while wb1 writes p20 = 0x77 (old value 0x11) -> same-cycle src1_val = 0x11 without PRF_WR_BYPASS_EN, 0x77 with it; 0x77 next cycle in both builds.
- Assert rst mid-burst of writes -> all entries read 0 and all ready bits = 1 on the following cycle.
